// File: rtl/rvv_inst_encoder_if.sv
// rvv_inst_encoder_if: request and instruction handshake bundle of the RVV instruction encoder
interface rvv_inst_encoder_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_kind;
  logic [7:0] req_funct8;
  logic [2:0] req_alu_type;
  logic       req_vm;
  logic [4:0] req_vd;
  logic [4:0] req_vs2;
  logic [4:0] req_src1;
  logic [1:0] req_mop;
  logic [4:0] req_umop;
  logic [2:0] req_nf;
  logic [2:0] req_width;
  logic [7:0] req_vtype;
  logic [4:0] req_avl_xreg;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        inst_is_cfg;
  modport master (
    output req_valid, req_kind, req_funct8, req_alu_type, req_vm, req_vd, req_vs2, req_src1,
           req_mop, req_umop, req_nf, req_width, req_vtype, req_avl_xreg, inst_ready,
    input  req_ready, inst_valid, inst_data, inst_is_cfg
  );
  modport slave (
    input  req_valid, req_kind, req_funct8, req_alu_type, req_vm, req_vd, req_vs2, req_src1,
           req_mop, req_umop, req_nf, req_width, req_vtype, req_avl_xreg, inst_ready,
    output req_ready, inst_valid, inst_data, inst_is_cfg
  );
endinterface

// File: rtl/rvv_inst_encoder.sv
// rvv_inst_encoder: assembles RVV requests into 32-bit encodings, inserting vsetvli on vtype change (RVV_ENC_VTYPE_ELIDE_EN enables elision)
module rvv_inst_encoder #(
  parameter logic [4:0] CFG_RD    = 5'd0,
  parameter int         ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rvv_inst_encoder_if.slave    bus,
  input  logic                 vtype_flush,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);
`ifdef RVV_ENC_VTYPE_ELIDE_EN
  localparam bit ELIDE = 1'b1;
`else
  localparam bit ELIDE = 1'b0;
`endif
  typedef enum logic {IDLE, CFG_PEND} state_t;
  state_t      state, state_d;
  logic [31:0] hold;
  logic [7:0]  cur_vtype;
  logic        vtype_known;
  logic [1:0]  cls;
  logic        alu_bad, illegal, acc, take, need_cfg;
  logic [31:0] alu_w, ls_w, cfg_w, enc_w;
  // request decode, legality and word assembly
  always_comb begin
    cls      = bus.req_funct8[7:6];
    alu_bad  = bus.req_alu_type inside {3'd1, 3'd5, 3'd7} || cls[1] ||
               (cls == 2'b00 && bus.req_alu_type inside {3'd2, 3'd6}) ||
               (cls == 2'b01 && bus.req_alu_type inside {3'd0, 3'd3, 3'd4});
    illegal  = bus.req_kind == 2'd3 || (bus.req_kind == 2'd0 && alu_bad);
    acc      = bus.req_valid && bus.req_ready;
    take     = acc && !illegal;
    need_cfg = !ELIDE || !vtype_known || vtype_flush || bus.req_vtype != cur_vtype;
    alu_w    = {bus.req_funct8[5:0], bus.req_vm, bus.req_vs2, bus.req_src1, bus.req_alu_type,
                bus.req_vd, 7'b1010111};
    ls_w     = {bus.req_nf, 1'b0, bus.req_mop, bus.req_vm,
                bus.req_mop == 2'd0 ? bus.req_umop : bus.req_vs2, bus.req_src1, bus.req_width,
                bus.req_vd, bus.req_kind == 2'd2 ? 7'b0100111 : 7'b0000111};
    cfg_w    = {4'b0, bus.req_vtype, bus.req_avl_xreg, 3'b111, CFG_RD, 7'b1010111};
    enc_w    = bus.req_kind == 2'd0 ? alu_w : ls_w;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  // next state: enter CFG_PEND when a vsetvli is inserted, leave on its handshake
  always_comb
    state_d = state == IDLE ? (take && need_cfg ? CFG_PEND : IDLE) : (bus.inst_ready ? IDLE : CFG_PEND);
  // FSM outputs: requests only accepted in IDLE when the output register can be refilled
  always_comb
    bus.req_ready = state == IDLE && (!bus.inst_valid || bus.inst_ready);
  // output and hold registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.inst_valid  <= 1'b0;
      bus.inst_data   <= '0;
      bus.inst_is_cfg <= 1'b0;
      hold            <= '0;
    end else if (take) begin
      bus.inst_valid  <= 1'b1;
      bus.inst_data   <= need_cfg ? cfg_w : enc_w;
      bus.inst_is_cfg <= need_cfg;
      if (need_cfg) hold <= enc_w;
    end else if (state == CFG_PEND && bus.inst_ready) begin
      bus.inst_data   <= hold;
      bus.inst_is_cfg <= 1'b0;
    end else if (bus.inst_ready) bus.inst_valid <= 1'b0;
  // vtype tracking: a flush clears knowledge unless this same accept re-establishes it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_vtype   <= '0;
      vtype_known <= 1'b0;
    end else if (take && need_cfg) begin
      cur_vtype   <= bus.req_vtype;
      vtype_known <= 1'b1;
    end else if (vtype_flush) vtype_known <= 1'b0;
  // rejected-request pulse and saturating counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= acc && illegal;
      if (acc && illegal && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
endmodule

// File: tb/tb_rvv_inst_encoder.sv
// tb_rvv_inst_encoder: directed scoreboard bench for rvv_inst_encoder
module tb_rvv_inst_encoder;
`ifdef RVV_ENC_VTYPE_ELIDE_EN
  localparam bit ELIDE = 1'b1;
`else
  localparam bit ELIDE = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vtype_flush = 1'b0;
  logic       err_pulse;
  logic [1:0] err_cnt;
  int checks = 0, failures = 0, err_seen = 0, cyc = 0, acc_cyc = 0;
  logic [32:0] q[$];
  logic       m_known = 1'b0;
  logic [7:0] m_vt = '0;
  rvv_inst_encoder_if ifc();
  rvv_inst_encoder #(.CFG_RD(5'd0), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .vtype_flush(vtype_flush),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && err_pulse) err_seen++;
    if (!rst && ifc.inst_valid && ifc.inst_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_inst: got %b/%h expected nothing", ifc.inst_is_cfg, ifc.inst_data);
      end else begin
        logic [32:0] e;
        e = q.pop_front();
        if ({ifc.inst_is_cfg, ifc.inst_data} !== e) begin
          failures++;
          $display("FAIL inst_word: got %b/%h expected %b/%h", ifc.inst_is_cfg, ifc.inst_data, e[32], e[31:0]);
        end
      end
    end
  end
  task automatic send(input logic [1:0] k, input logic [7:0] f8, input logic [2:0] t, input logic vm,
                      input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] s1,
                      input logic [1:0] mop, input logic [4:0] umop, input logic [2:0] nf,
                      input logic [2:0] w, input logic [7:0] vt, input logic [4:0] avl, input logic fl,
                      input logic bad, input logic [31:0] exp_w, input logic [31:0] exp_cfg);
    int n;
    logic need;
    ifc.req_kind = k; ifc.req_funct8 = f8; ifc.req_alu_type = t; ifc.req_vm = vm;
    ifc.req_vd = vd; ifc.req_vs2 = vs2; ifc.req_src1 = s1; ifc.req_mop = mop; ifc.req_umop = umop;
    ifc.req_nf = nf; ifc.req_width = w; ifc.req_vtype = vt; ifc.req_avl_xreg = avl;
    ifc.req_valid = 1'b1; vtype_flush = fl;
    n = 0;
    while (!ifc.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ifc.req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      ifc.req_valid = 1'b0; vtype_flush = 1'b0;
      return;
    end
    if (fl) m_known = 1'b0;
    if (!bad) begin
      need = !ELIDE || !m_known || vt != m_vt;
      if (need) begin
        q.push_back({1'b1, exp_cfg});
        m_known = 1'b1; m_vt = vt;
      end
      q.push_back({1'b0, exp_w});
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0; vtype_flush = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic alu1(input logic [7:0] vt, input logic fl, input logic [31:0] cfg);
    send(2'd0, 8'h00, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 5'd0, 3'd0, 3'd0, vt, 5'd5, fl, 1'b0,
         32'h022180D7, cfg);
  endtask
  initial begin
    int a0;
    ifc.req_valid = 1'b0; ifc.inst_ready = 1'b1;
    ifc.req_kind = '0; ifc.req_funct8 = '0; ifc.req_alu_type = '0; ifc.req_vm = '0;
    ifc.req_vd = '0; ifc.req_vs2 = '0; ifc.req_src1 = '0; ifc.req_mop = '0; ifc.req_umop = '0;
    ifc.req_nf = '0; ifc.req_width = '0; ifc.req_vtype = '0; ifc.req_avl_xreg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_valid", ifc.inst_valid, 0);
    chk("rst_inst_data", ifc.inst_data, 0);
    chk("rst_inst_is_cfg", ifc.inst_is_cfg, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_req_ready", ifc.req_ready, 1);
    rst = 1'b0;
    alu1(8'h10, 1'b0, 32'h0102F057);
    chk("first_latency_valid", ifc.inst_valid, 1);
    chk("first_latency_data", ifc.inst_data, 32'h0102F057);
    chk("first_latency_cfg", ifc.inst_is_cfg, 1);
    alu1(8'h10, 1'b0, 32'h0102F057);
    chk("second_is_cfg", ifc.inst_is_cfg, !ELIDE);
    alu1(8'h10, 1'b0, 32'h0102F057);
    a0 = acc_cyc;
    alu1(8'h10, 1'b0, 32'h0102F057);
    alu1(8'h10, 1'b0, 32'h0102F057);
    chk("throughput_cycles", acc_cyc - a0, ELIDE ? 2 : 4);
    send(2'd1, 8'h00, 3'd0, 1'b1, 5'd4, 5'd0, 5'd10, 2'd0, 5'd0, 3'd0, 3'd6, 8'h10, 5'd5, 1'b0, 1'b0,
         32'h02056207, 32'h0102F057);
    send(2'd2, 8'h00, 3'd0, 1'b0, 5'd8, 5'd7, 5'd9, 2'd2, 5'd3, 3'd1, 3'd5, 8'h10, 5'd5, 1'b0, 1'b0,
         32'h2874D427, 32'h0102F057);
    send(2'd0, 8'h65, 3'd2, 1'b1, 5'd3, 5'd4, 5'd5, 2'd0, 5'd0, 3'd0, 3'd0, 8'h10, 5'd5, 1'b0, 1'b0,
         32'h9642A1D7, 32'h0102F057);
    send(2'd0, 8'h00, 3'd3, 1'b0, 5'd6, 5'd7, 5'd31, 2'd0, 5'd0, 3'd0, 3'd0, 8'h51, 5'd12, 1'b0, 1'b0,
         32'h007FB357, 32'h05167057);
    drain();
    send(2'd0, 8'h00, 3'd1, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 5'd0, 3'd0, 3'd0, 8'hAA, 5'd5, 1'b0, 1'b1, 0, 0);
    chk("illegal_no_valid", ifc.inst_valid, 0);
    chk("err_pulse_high", err_pulse, 1);
    chk("err_cnt_one", err_cnt, 1);
    send(2'd3, 8'h00, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 5'd0, 3'd0, 3'd0, 8'hAA, 5'd5, 1'b0, 1'b1, 0, 0);
    send(2'd0, 8'h80, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 5'd0, 3'd0, 3'd0, 8'hAA, 5'd5, 1'b0, 1'b1, 0, 0);
    send(2'd0, 8'h00, 3'd6, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 5'd0, 3'd0, 3'd0, 8'hAA, 5'd5, 1'b0, 1'b1, 0, 0);
    send(2'd0, 8'h40, 3'd4, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0, 5'd0, 3'd0, 3'd0, 8'hAA, 5'd5, 1'b0, 1'b1, 0, 0);
    @(posedge clk); #1;
    chk("err_pulse_low", err_pulse, 0);
    chk("err_cnt_sat", err_cnt, 3);
    chk("err_pulse_cycles", err_seen, 5);
    chk("illegal_no_emit", ifc.inst_valid, 0);
    send(2'd0, 8'h00, 3'd3, 1'b0, 5'd6, 5'd7, 5'd31, 2'd0, 5'd0, 3'd0, 3'd0, 8'h51, 5'd12, 1'b0, 1'b0,
         32'h007FB357, 32'h05167057);
    drain();
    ifc.inst_ready = 1'b0;
    alu1(8'h10, 1'b0, 32'h0102F057);
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_ready", ifc.req_ready, 0);
      chk("stall_valid", ifc.inst_valid, 1);
      chk("stall_data", ifc.inst_data, 32'h0102F057);
      chk("stall_is_cfg", ifc.inst_is_cfg, 1);
      @(posedge clk); #1;
    end
    ifc.inst_ready = 1'b1;
    alu1(8'h10, 1'b1, 32'h0102F057);
    drain();
    ifc.inst_ready = 1'b0;
    alu1(8'h33, 1'b0, 32'h0332F057);
    chk("pre_rst_data", ifc.inst_data, 32'h0332F057);
    rst = 1'b1;
    q.delete();
    m_known = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", ifc.inst_valid, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_req_ready", ifc.req_ready, 1);
    rst = 1'b0;
    ifc.inst_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", ifc.inst_valid, 0);
    alu1(8'h10, 1'b0, 32'h0102F057);
    chk("post_rst_cfg", ifc.inst_is_cfg, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
